// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI4 read/write bus bundle between the arbiter master port and the SRAM slave
//
// Purpose: carries every AR/R/AW/W/B channel signal of one AXI4 link. Signal
// names keep the slave-side i_/o_ direction prefixes so that the slave's view
// reads naturally.
//   slave modport  : i_axi_* are inputs, o_axi_* are outputs
//   master modport : the reverse (used by the upstream arbiter or a bench)
interface axi_sram_slave_if;
  // AR channel
  logic [31:0] i_axi_araddr;
  logic        i_axi_arvalid;
  logic        o_axi_arready;
  logic [3:0]  i_axi_arid;
  logic [7:0]  i_axi_arlen;
  // R channel
  logic [31:0] o_axi_rdata;
  logic        o_axi_rvalid;
  logic [1:0]  o_axi_rresp;
  logic        i_axi_rready;
  logic [3:0]  o_axi_rid;
  logic        o_axi_rlast;
  // AW channel
  logic [31:0] i_axi_awaddr;
  logic        i_axi_awvalid;
  logic        o_axi_awready;
  logic [3:0]  i_axi_awid;
  logic [7:0]  i_axi_awlen;
  // W channel
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        i_axi_wvalid;
  logic        o_axi_wready;
  logic        i_axi_wlast;
  // B channel
  logic [1:0]  o_axi_bresp;
  logic        o_axi_bvalid;
  logic        i_axi_bready;
  logic [3:0]  o_axi_bid;

  modport slave (
    input  i_axi_araddr, i_axi_arvalid, i_axi_arid, i_axi_arlen, i_axi_rready,
    input  i_axi_awaddr, i_axi_awvalid, i_axi_awid, i_axi_awlen,
    input  i_axi_wdata, i_axi_wstrb, i_axi_wvalid, i_axi_wlast, i_axi_bready,
    output o_axi_arready, o_axi_rdata, o_axi_rvalid, o_axi_rresp, o_axi_rid, o_axi_rlast,
    output o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid, o_axi_bid
  );

  modport master (
    output i_axi_araddr, i_axi_arvalid, i_axi_arid, i_axi_arlen, i_axi_rready,
    output i_axi_awaddr, i_axi_awvalid, i_axi_awid, i_axi_awlen,
    output i_axi_wdata, i_axi_wstrb, i_axi_wvalid, i_axi_wlast, i_axi_bready,
    input  o_axi_arready, o_axi_rdata, o_axi_rvalid, o_axi_rresp, o_axi_rid, o_axi_rlast,
    input  o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid, o_axi_bid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 INCR-burst slave serving a word-addressed SRAM array
//
// Purpose: independent read and write FSMs in front of a DEPTH_WORDS x 32 array
// mapped at ADDR_BASE. Reads wait READ_LAT cycles before the first beat; writes
// honour byte strobes; any beat outside the window answers SLVERR.
// Ports:
//   i_clock    clock
//   i_reset_n  asynchronous active-low reset (array contents are kept)
//   axi        slave side of the AXI4 bundle (AR/R/AW/W/B channels)
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 2
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  axi_sram_slave_if.slave axi
);
  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT       = 4'(READ_LAT);

  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Offset is unsigned, so addresses below the base wrap to huge values and fail too.
  function automatic logic in_win(input logic [31:0] addr);
    return (addr - ADDR_BASE) < WIN_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  // ---------------- read path ----------------
  logic [1:0]  r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [3:0]  r_lat_q, r_lat_d;
  logic [7:0]  r_beat_q, r_beat_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic        r_last_q, r_last_d;
  logic        r_load;
  logic [31:0] r_ld_base, r_ld_addr;
  logic [7:0]  r_ld_beat, r_ld_len;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_lat_d   = r_lat_q;
    r_beat_d  = r_beat_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    r_load    = 1'b0;
    r_ld_base = r_addr_q;
    r_ld_beat = r_beat_q;
    r_ld_len  = r_len_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.i_axi_arvalid) begin
          r_addr_d = axi.i_axi_araddr;
          r_id_d   = axi.i_axi_arid;
          r_len_d  = axi.i_axi_arlen;
          r_beat_d = 8'd0;
          r_lat_d  = LAT;
          if (LAT == 4'd0) begin
            // No wait phase: first beat is captured on the handshake edge itself.
            r_load    = 1'b1;
            r_ld_base = axi.i_axi_araddr;
            r_ld_beat = 8'd0;
            r_ld_len  = axi.i_axi_arlen;
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_lat_q == 4'd0) begin
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end else begin
          r_lat_d = r_lat_q - 4'd1;
        end
      end
      R_DATA: begin
        if (r_valid_q && axi.i_axi_rready) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_beat_d  = r_beat_q + 8'd1;
            r_ld_beat = r_beat_q + 8'd1;
            r_load    = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_ld_addr = r_ld_base + {22'd0, r_ld_beat, 2'b00};
    if (r_load) begin
      r_valid_d = 1'b1;
      r_last_d  = (r_ld_beat == r_ld_len);
      if (in_win(r_ld_addr)) begin
        r_data_d = mem_q[word_idx(r_ld_addr)];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = 32'd0;
        r_resp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_id_q    <= 4'd0;
      r_len_q   <= 8'd0;
      r_lat_q   <= 4'd0;
      r_beat_q  <= 8'd0;
      r_valid_q <= 1'b0;
      r_data_q  <= 32'd0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_lat_q   <= r_lat_d;
      r_beat_q  <= r_beat_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  assign axi.o_axi_arready = (r_state_q == R_IDLE);
  assign axi.o_axi_rvalid  = r_valid_q;
  assign axi.o_axi_rdata   = r_data_q;
  assign axi.o_axi_rresp   = r_resp_q;
  assign axi.o_axi_rlast   = r_last_q;
  assign axi.o_axi_rid     = r_id_q;

  // ---------------- write path ----------------
  logic [1:0]  w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [3:0]  w_id_q, w_id_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [8:0]  w_beat_q, w_beat_d;   // one extra bit so overrun beats never alias
  logic        w_err_q, w_err_d;
  logic        w_hs, w_ok, mem_we;
  logic [31:0] w_cur_addr;

  assign w_hs       = axi.i_axi_wvalid && (w_state_q == W_DATA);
  assign w_cur_addr = w_addr_q + {21'd0, w_beat_q, 2'b00};
  assign w_ok       = (w_beat_q <= {1'b0, w_len_q}) && in_win(w_cur_addr);
  assign mem_we     = w_hs && w_ok;

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi.i_axi_awvalid) begin
          w_addr_d  = axi.i_axi_awaddr;
          w_id_d    = axi.i_axi_awid;
          w_len_d   = axi.i_axi_awlen;
          w_beat_d  = 9'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (!w_ok) w_err_d = 1'b1;
          if (w_beat_q != 9'h1FF) w_beat_d = w_beat_q + 9'd1;
          if (axi.i_axi_wlast) begin
            // Early or late wlast means the burst did not match its announced length.
            if (w_beat_q != {1'b0, w_len_q}) w_err_d = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi.i_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 32'd0;
      w_id_q    <= 4'd0;
      w_len_q   <= 8'd0;
      w_beat_q  <= 9'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  // Array has no reset; a write committing here is not seen by a read loading on the same edge.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.i_axi_wstrb[b]) mem_q[word_idx(w_cur_addr)][8*b +: 8] <= axi.i_axi_wdata[8*b +: 8];
      end
    end
  end

  assign axi.o_axi_awready = (w_state_q == W_IDLE);
  assign axi.o_axi_wready  = (w_state_q == W_DATA);
  assign axi.o_axi_bvalid  = (w_state_q == W_RESP);
  assign axi.o_axi_bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.o_axi_bid     = w_id_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave against a memory model
module tb_axi_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_slave_if axi ();

  axi_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_LAT(LAT)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .axi      (axi)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: byte-merged word array plus a flag for fully-defined words.
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] last_rdata;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input logic [3:0] id, input int gap);
    bit err;
    int n;
    logic [31:0] a;
    err = 0;
    for (int i = 0; i < nbeats; i++) begin
      a = addr + 32'(4 * i);
      if (i > int'(len) || !in_win(a)) err = 1;
      else begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[idx(a)][8*b +: 8] = wd[i][8*b +: 8];
        if (ws[i] == 4'hF) known[idx(a)] = 1;
      end
    end
    if (nbeats - 1 != int'(len)) err = 1;

    axi.i_axi_awaddr = addr; axi.i_axi_awlen = len; axi.i_axi_awid = id; axi.i_axi_awvalid = 1;
    n = 0;
    while (!axi.o_axi_awready && n < 100) begin @(negedge clk); n++; end
    check("aw_ready", axi.o_axi_awready, 1);
    @(negedge clk);
    axi.i_axi_awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      axi.i_axi_wvalid = 0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      axi.i_axi_wdata = wd[i]; axi.i_axi_wstrb = ws[i];
      axi.i_axi_wlast = (i == nbeats - 1); axi.i_axi_wvalid = 1;
      n = 0;
      while (!axi.o_axi_wready && n < 100) begin @(negedge clk); n++; end
      check("w_ready", axi.o_axi_wready, 1);
      @(negedge clk);
    end
    axi.i_axi_wvalid = 0; axi.i_axi_wlast = 0;
    n = 0;
    while (!axi.o_axi_bvalid && n < 100) begin @(negedge clk); n++; end
    check("b_valid", axi.o_axi_bvalid, 1);
    check("b_resp", axi.o_axi_bresp, err ? 2'b10 : 2'b00);
    check("b_id", axi.o_axi_bid, id);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("b_hold", axi.o_axi_bvalid, 1);
    end
    axi.i_axi_bready = 1;
    @(negedge clk);
    axi.i_axi_bready = 0;
    check("aw_ready_after_b", axi.o_axi_awready, 1);
  endtask

  // mode: 0 random rready, 1 toggling rready, 2 rready held high. stop>0 leaves after that many beats.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int mode, input int stop);
    int n, hs, b;
    bit stalled, tog;
    logic [31:0] held, a, exp_d;
    logic [1:0] exp_r;
    axi.i_axi_araddr = addr; axi.i_axi_arlen = len; axi.i_axi_arid = id; axi.i_axi_arvalid = 1;
    n = 0;
    while (!axi.o_axi_arready && n < 100) begin @(negedge clk); n++; end
    check("ar_ready", axi.o_axi_arready, 1);
    @(negedge clk);
    axi.i_axi_arvalid = 0;
    hs = cyc;
    n = 0;
    while (!axi.o_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    check("r_latency", 32'(cyc - hs), 32'(LAT + 1));
    b = 0; stalled = 0; tog = 1; n = 0;
    while (b <= int'(len) && (stop == 0 || b < stop) && n < 2000) begin
      if (axi.o_axi_rvalid) begin
        if (stalled) check("r_hold", axi.o_axi_rdata, held);
        case (mode)
          0: axi.i_axi_rready = 1'($urandom_range(0, 1));
          1: begin axi.i_axi_rready = tog; tog = !tog; end
          default: axi.i_axi_rready = 1;
        endcase
        if (axi.i_axi_rready) begin
          a = addr + 32'(4 * b);
          if (!in_win(a)) begin exp_d = 0; exp_r = 2'b10; end
          else begin exp_d = model[idx(a)]; exp_r = 2'b00; end
          if (!in_win(a) || known[idx(a)]) check("r_data", axi.o_axi_rdata, exp_d);
          check("r_resp", axi.o_axi_rresp, exp_r);
          check("r_last", axi.o_axi_rlast, 32'(b == int'(len)));
          check("r_id", axi.o_axi_rid, id);
          last_rdata = axi.o_axi_rdata;
          b++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = axi.o_axi_rdata;
        end
      end else axi.i_axi_rready = 0;
      @(negedge clk);
      n++;
    end
    axi.i_axi_rready = 0;
    check("r_beats", 32'(b), (stop != 0) ? 32'(stop) : 32'(int'(len) + 1));
    if (stop == 0) begin
      check("ar_ready_idle", axi.o_axi_arready, 1);
      check("r_valid_idle", axi.o_axi_rvalid, 0);
    end
  endtask

  initial begin
    bit seen;
    logic [7:0] len;
    int nb;
    logic [31:0] addr;
    axi.i_axi_araddr = 0; axi.i_axi_arvalid = 0; axi.i_axi_arid = 0; axi.i_axi_arlen = 0;
    axi.i_axi_rready = 0; axi.i_axi_awaddr = 0; axi.i_axi_awvalid = 0; axi.i_axi_awid = 0;
    axi.i_axi_awlen = 0; axi.i_axi_wdata = 0; axi.i_axi_wstrb = 0; axi.i_axi_wvalid = 0;
    axi.i_axi_wlast = 0; axi.i_axi_bready = 0;
    repeat (3) @(negedge clk);
    check("rst_rvalid_in", axi.o_axi_rvalid, 0);
    check("rst_bvalid_in", axi.o_axi_bvalid, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_arready", axi.o_axi_arready, 1);
    check("rst_awready", axi.o_axi_awready, 1);
    check("rst_wready", axi.o_axi_wready, 0);
    check("rst_rdata", axi.o_axi_rdata, 0);
    check("rst_rresp", axi.o_axi_rresp, 0);
    check("rst_rlast", axi.o_axi_rlast, 0);
    check("rst_rid", axi.o_axi_rid, 0);
    check("rst_bresp", axi.o_axi_bresp, 0);
    check("rst_bid", axi.o_axi_bid, 0);

    // Single write then read with latency check.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(BASE + 32'h10, 8'd0, 1, 4'h3, 0);
    axi_read(BASE + 32'h10, 8'd0, 4'h5, 2, 0);
    check("single_rdata", last_rdata, 32'hDEADBEEF);

    // 4-beat burst, read back with rready toggling.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(BASE + 32'h100, 8'd3, 4, 4'h1, 2);
    axi_read(BASE + 32'h100, 8'd3, 4'h6, 1, 0);
    check("burst_last_rdata", last_rdata, 32'd4);

    // Byte strobe merge.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(BASE + 32'h200, 8'd0, 1, 4'h2, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(BASE + 32'h200, 8'd0, 1, 4'h2, 0);
    axi_read(BASE + 32'h200, 8'd0, 4'h2, 2, 0);
    check("strb_merge", last_rdata, 32'h11BB33DD);

    // Out-of-window read and write; word 0 must survive the aliasing write.
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    axi_write(BASE, 8'd0, 1, 4'h4, 0);
    axi_read(32'h7FFF_FFFC, 8'd0, 4'h7, 2, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(BASE + 32'(4 * DEPTH), 8'd0, 1, 4'h8, 0);
    axi_read(BASE, 8'd0, 4'h7, 2, 0);
    check("oow_unchanged", last_rdata, 32'h0BADF00D);

    // Burst straddling the top of the window.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
    axi_write(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 4, 4'hA, 1);
    axi_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 4'hB, 0, 0);

    // Early wlast: awlen=3 but only two beats.
    wd[0] = 32'h5555_0001; wd[1] = 32'h5555_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(BASE + 32'h300, 8'd3, 2, 4'h9, 0);
    axi_read(BASE + 32'h300, 8'd1, 4'h9, 2, 0);
    check("early_wlast_beat2", last_rdata, 32'h5555_0002);

    // Reset in the middle of an 8-beat read.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hA000_0000 + 32'(i * 17); ws[i] = 4'hF; end
    axi_write(BASE + 32'h400, 8'd7, 8, 4'hC, 0);
    axi_read(BASE + 32'h400, 8'd7, 4'hD, 2, 3);
    rst_n = 0;
    #1;
    check("midrst_rvalid", axi.o_axi_rvalid, 0);
    check("midrst_rlast", axi.o_axi_rlast, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (axi.o_axi_rvalid) seen = 1;
    end
    check("post_rst_no_rvalid", 32'(seen), 0);
    check("post_rst_arready", axi.o_axi_arready, 1);
    check("post_rst_awready", axi.o_axi_awready, 1);
    axi_read(BASE + 32'h400, 8'd7, 4'hE, 2, 0);

    // Randomized traffic over a 64-word window; fill it fully first.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(BASE + 32'h800 + 32'(blk * 32), 8'd7, 8, 4'($urandom), 1);
    end
    for (int it = 0; it < 40; it++) begin
      len = 8'($urandom_range(0, 7));
      nb = int'(len) + 1;
      if ($urandom_range(0, 5) == 0) nb = int'(len) + 2;
      if ($urandom_range(0, 5) == 0 && len != 0) nb = int'(len);
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      addr = BASE + 32'h800 + 32'(4 * $urandom_range(0, 55));
      axi_write(addr, len, nb, 4'($urandom), 2);
      len = 8'($urandom_range(0, 7));
      addr = BASE + 32'h800 + 32'(4 * $urandom_range(0, 56));
      axi_read(addr, len, 4'($urandom), $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 memory slave directly downstream of the NPC read/write arbiter; consumes its single merged master port and serves reads/writes from an internal word-addressed array.
Supports INCR bursts (4-byte beats only), a programmable read latency, byte strobes, and SLVERR for out-of-window accesses.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, array depth in 32-bit words (power of two); IDX_W = clog2(DEPTH_WORDS)
READ_LAT, 2, wait cycles between AR handshake and first rvalid (0..15)

Ports:
i_clock  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_axi_araddr  in  32  read byte address
i_axi_arvalid  in  1  AR valid
o_axi_arready  out  1  AR ready
i_axi_arid  in  4  read ID
i_axi_arlen  in  8  beats-1
o_axi_rdata  out  32  read data
o_axi_rvalid  out  1  R valid
o_axi_rresp  out  2  00 OKAY, 10 SLVERR
i_axi_rready  in  1  R ready
o_axi_rid  out  4  echoed arid
o_axi_rlast  out  1  final beat
i_axi_awaddr  in  32  write byte address
i_axi_awvalid  in  1  AW valid
o_axi_awready  out  1  AW ready
i_axi_awid  in  4  write ID
i_axi_awlen  in  8  beats-1
i_axi_wdata  in  32  write data
i_axi_wstrb  in  4  byte enables
i_axi_wvalid  in  1  W valid
o_axi_wready  out  1  W ready
i_axi_wlast  in  1  final W beat
o_axi_bresp  out  2  00 OKAY, 10 SLVERR
o_axi_bvalid  out  1  B valid
i_axi_bready  in  1  B ready
o_axi_bid  out  4  echoed awid

Behaviour:
- Reset: i_reset_n low asynchronously forces both FSMs idle, counters 0, all outputs 0 except o_axi_arready=o_axi_awready=1 after release; array contents not cleared. Reset mid-burst abandons the burst; no further R/B beats issued.
- Address map: beat in range iff ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS; index = (addr-ADDR_BASE)[IDX_W+1:2]; addr[1:0] ignored. Beat address = latched addr + 4*beat, 32-bit wrap.
- Read FSM R_IDLE/R_WAIT/R_DATA: arready=1 only in R_IDLE. AR handshake latches addr/id/len, loads latency counter = READ_LAT, beat count 0; goes to R_WAIT, or R_DATA directly if READ_LAT=0. R_WAIT decrements each cycle, enters R_DATA at 0.
- R_DATA: rvalid=1; rdata/rresp/rlast registered, stable while rvalid && !rready. rdata = array word at beat address on the loading edge (write committing on same edge not visible); out-of-range beat: rdata=0, rresp=10. rlast=1 iff beat count==len. On rvalid&&rready: not last -> next beat presented next cycle (one beat/cycle max with rready held); last -> R_IDLE, arready=1 next cycle.
- Write FSM W_IDLE/W_DATA/W_RESP: awready=1 only in W_IDLE. AW handshake latches addr/id/len, clears beat count and error flag, enters W_DATA; wready=1 in W_DATA only (W before AW is held off).
- Each W handshake: in-range and beat count<=len -> bytes with wstrb[i]=1 written; out-of-range sets error; beats past len dropped and set error. wlast handshake ends data phase -> W_RESP; if beat count!=len at wlast, set error.
- W_RESP: bvalid=1, bid=latched id, bresp=10 if error else 00; held until bready; then W_IDLE, awready=1 next cycle.
- Read and write FSMs independent; concurrent operation allowed.

Test Plan:
- Reset release, READ_LAT=2: single read 0x8000_0010 after write 0xDEADBEEF -> rvalid exactly 3 cycles after AR handshake (2 wait + load), rdata=0xDEADBEEF, rresp=00, rlast=1, rid echoed.
- 4-beat INCR write 0x8000_0100 data 1..4 then arlen=3 read, rready toggling 1/0 -> beats 1,2,3,4 in order, rdata held during stalls, rlast only on beat 4.
- Write wstrb=4'b0101 data 0xAABBCCDD over 0x11223344 -> read 0x11BB33DD.
- Read 0x7FFF_FFFC and write to 0x8000_0000+4*DEPTH_WORDS -> rresp=10 rdata=0; bresp=10; array unchanged.
- awlen=3 with wlast on beat 2 -> bresp=10; beats 1-2 written, bid echoed.
- Assert i_reset_n low mid 8-beat read after beat 3 -> rvalid drops immediately, arready=1 after release, next read returns correct data.
